ifid_stage: RTL



---
 rtl/ifid_pkg.sv | 21 ++
 rtl/ifid_hazard_detect.sv | 18 +
 rtl/ifid_stage.sv | 95 +++++++++
 3 files changed

// File: rtl/ifid_pkg.sv
// Shared constants for the IF/ID stage: instruction field ranges, register-0 index
// and the default squash word.
package ifid_pkg;

    localparam logic [31:0] NOP_WORD_DEFAULT = 32'h0000_0000;

    localparam int OP_MSB = 31;
    localparam int OP_LSB = 26;
    localparam int RS_MSB = 25;
    localparam int RS_LSB = 21;
    localparam int RT_MSB = 20;
    localparam int RT_LSB = 16;

    localparam int          REG_W    = 5;
    localparam logic [4:0]  REG_ZERO = 5'd0;

    function automatic logic [5:0] opcode_of(input logic [31:0] word);
        return word[OP_MSB:OP_LSB];
    endfunction

endpackage

// File: rtl/ifid_hazard_detect.sv
// Load-use hazard detector: the instruction in ID reads the register that the load
// currently in EX will write. Purely combinational.
module ifid_hazard_detect
    import ifid_pkg::*;
(
    input  logic             id_valid,
    input  logic [REG_W-1:0] rs,
    input  logic [REG_W-1:0] rt,
    input  logic             ex_mem_read,
    input  logic [REG_W-1:0] ex_rt,
    output logic             hazard
);

    // Register 0 is hard-wired, so a load targeting it never creates a dependency.
    assign hazard = id_valid & ex_mem_read & (ex_rt != REG_ZERO)
                  & ((ex_rt == rs) | (ex_rt == rt));

endmodule

// File: rtl/ifid_stage.sv
// IF/ID pipeline register with load-use stall, flush squash and stall/bubble control.
// Optional saturating performance counters are enabled by defining IFID_PERF_CNT_EN.
module ifid_stage
    import ifid_pkg::*;
#(
    parameter logic [31:0] NOP_WORD = NOP_WORD_DEFAULT,
    parameter int          CNT_W    = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [31:0]      if_instruction,
    input  logic [31:0]      if_pcplus4,
    input  logic             ex_mem_read,
    input  logic [4:0]       ex_rt,
    input  logic             flush,
    input  logic             ext_stall,
    output logic [31:0]      id_instruction,
    output logic [31:0]      id_pcplus4,
    output logic             id_valid,
    output logic             pc_write,
    output logic             id_bubble,
    output logic [CNT_W-1:0] stall_count,
    output logic [CNT_W-1:0] flush_count
);

    logic [31:0] id_instruction_reg;
    logic [31:0] id_pcplus4_reg;
    logic        id_valid_reg;
    logic        hazard;

    ifid_hazard_detect u_hazard (
        .id_valid    (id_valid_reg),
        .rs          (id_instruction_reg[RS_MSB:RS_LSB]),
        .rt          (id_instruction_reg[RT_MSB:RT_LSB]),
        .ex_mem_read (ex_mem_read),
        .ex_rt       (ex_rt),
        .hazard      (hazard)
    );

    // Flush outranks both stall sources so a redirect is never dropped.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            id_instruction_reg <= NOP_WORD;
            id_pcplus4_reg     <= 32'd0;
            id_valid_reg       <= 1'b0;
        end else if (flush) begin
            id_instruction_reg <= NOP_WORD;
            id_pcplus4_reg     <= 32'd0;
            id_valid_reg       <= 1'b0;
        end else if (!(ext_stall | hazard)) begin
            id_instruction_reg <= if_instruction;
            id_pcplus4_reg     <= if_pcplus4;
            id_valid_reg       <= 1'b1;
        end
    end

    assign id_instruction = id_instruction_reg;
    assign id_pcplus4     = id_pcplus4_reg;
    assign id_valid       = id_valid_reg;

    // No bubble under ext_stall: ID/EX is frozen too, the hazard re-evaluates on release.
    assign pc_write  = flush | ~(ext_stall | hazard);
    assign id_bubble = flush | (hazard & ~ext_stall);

`ifdef IFID_PERF_CNT_EN
    logic [1:0]       cnt_event;
    logic [CNT_W-1:0] cnt_value [2];

    assign cnt_event[0] = hazard & ~ext_stall & ~flush;
    assign cnt_event[1] = flush;

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_cnt
            logic [CNT_W-1:0] cnt_reg;

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    cnt_reg <= '0;
                end else if (cnt_event[gi] && (cnt_reg != {CNT_W{1'b1}})) begin
                    cnt_reg <= cnt_reg + CNT_W'(1);
                end
            end

            assign cnt_value[gi] = cnt_reg;
        end
    endgenerate

    assign stall_count = cnt_value[0];
    assign flush_count = cnt_value[1];
`else
    assign stall_count = '0;
    assign flush_count = '0;
`endif

endmodule
